// File: rtl/nbit_pred_pkg.sv
// nbit_pred_pkg: shared mode constants and saturating-counter helpers for the predictor
package nbit_pred_pkg;
  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE = 1;
  function automatic int ctr_init(int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction
  function automatic int sat_inc(int v, int max);
    return v >= max ? max : v + 1;
  endfunction
  function automatic int sat_dec(int v);
    return v <= 0 ? 0 : v - 1;
  endfunction
endpackage

// File: rtl/nbit_predictor_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);
  // count enabled events, holding once every bit is set
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/nbit_predictor.sv
// nbit_predictor: saturating-counter branch predictor, bimodal or gshare indexed, with hit statistics
module nbit_predictor
  import nbit_pred_pkg::*;
#(
  parameter int CTR_BITS = 2,
  parameter int IDX_BITS = 4,
  parameter int MODE = 0,
  parameter int HIST_BITS = 4,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [IDX_BITS-1:0] branchnumber,
  input  logic                in,
  output logic                out,
  output logic [CNT_W-1:0]    mismatch,
  output logic [CNT_W-1:0]    total
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam int MAXC = (1 << CTR_BITS) - 1;
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_init(CTR_BITS));
  if (CTR_BITS < 1 || CTR_BITS > 4 || HIST_BITS < 1 || HIST_BITS > IDX_BITS ||
      (MODE != MODE_BIMODAL && MODE != MODE_GSHARE)) begin : g_bad_params
    $error("nbit_predictor: illegal CTR_BITS/HIST_BITS/MODE");
  end
  logic [CTR_BITS-1:0]  tbl [DEPTH];
  logic [HIST_BITS-1:0] ghr;
  logic [IDX_BITS-1:0]  idx;
  logic [CTR_BITS-1:0]  nxt;
  // index selection and the counter value the entry moves to on this outcome
  always_comb begin
    idx = MODE == MODE_GSHARE ? branchnumber ^ IDX_BITS'(ghr) : branchnumber;
    nxt = in ? CTR_BITS'(sat_inc(int'(tbl[idx]), MAXC)) : CTR_BITS'(sat_dec(int'(tbl[idx])));
  end
  assign out = tbl[idx][CTR_BITS-1];
  // table held in flops so the async reset can restore every entry to weakly not-taken
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) tbl[i] <= INIT;
    else if (valid) tbl[idx] <= nxt;
  // global history shift register; the shift form also covers a one-bit history
  always_ff @(posedge clk or negedge reset)
    if (!reset) ghr <= '0;
    else if (valid && MODE == MODE_GSHARE) ghr <= (ghr << 1) | HIST_BITS'(in);
  sat_counter #(.W(CNT_W)) u_total (.clk(clk), .reset(reset), .en(valid), .count(total));
  sat_counter #(.W(CNT_W)) u_mismatch (.clk(clk), .reset(reset), .en(valid && out != in), .count(mismatch));
endmodule

// File: tb/tb_nbit_predictor.sv
// tb_nbit_predictor: directed vectors and corner sequences across four predictor configurations
module tb_nbit_predictor;
  typedef struct {
    logic       v;
    logic [3:0] bn;
    logic       in;
    logic       eo;
    int         em;
    int         et;
  } vec_t;
  logic clk = 0, reset = 0, valid = 0, in = 0;
  logic [3:0] bn = 0;
  logic out_a, out_b, out_g, out_c;
  logic [31:0] mis_a, tot_a, mis_b, tot_b, mis_g, tot_g;
  logic [3:0] mis_c, tot_c;
  int tests = 0, failed = 0;
  vec_t vecs[10];
  always #5 clk = ~clk;
  nbit_predictor #(.CTR_BITS(2), .MODE(0)) u_a (.clk(clk), .reset(reset), .valid(valid), .branchnumber(bn), .in(in), .out(out_a), .mismatch(mis_a), .total(tot_a));
  nbit_predictor #(.CTR_BITS(1), .MODE(0)) u_b (.clk(clk), .reset(reset), .valid(valid), .branchnumber(bn), .in(in), .out(out_b), .mismatch(mis_b), .total(tot_b));
  nbit_predictor #(.CTR_BITS(2), .MODE(1), .HIST_BITS(1)) u_g (.clk(clk), .reset(reset), .valid(valid), .branchnumber(bn), .in(in), .out(out_g), .mismatch(mis_g), .total(tot_g));
  nbit_predictor #(.CTR_BITS(2), .MODE(0), .CNT_W(4)) u_c (.clk(clk), .reset(reset), .valid(valid), .branchnumber(bn), .in(in), .out(out_c), .mismatch(mis_c), .total(tot_c));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [3:0] b, input logic i);
    @(negedge clk);
    valid = v;
    bn = b;
    in = i;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    valid = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    vecs[0] = '{1'b1, 4'd3, 1'b1, 1'b0, 1, 1};
    vecs[1] = '{1'b1, 4'd3, 1'b1, 1'b1, 1, 2};
    vecs[2] = '{1'b1, 4'd3, 1'b1, 1'b1, 1, 3};
    vecs[3] = '{1'b1, 4'd3, 1'b0, 1'b1, 2, 4};
    vecs[4] = '{1'b1, 4'd3, 1'b0, 1'b1, 3, 5};
    vecs[5] = '{1'b0, 4'd3, 1'b1, 1'b0, 3, 5};
    vecs[6] = '{1'b1, 4'd1, 1'b1, 1'b0, 4, 6};
    vecs[7] = '{1'b1, 4'd1, 1'b1, 1'b1, 4, 7};
    vecs[8] = '{1'b0, 4'd2, 1'b1, 1'b0, 4, 7};
    vecs[9] = '{1'b0, 4'd1, 1'b0, 1'b1, 4, 7};
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("reset_out", out_a, 0);
    chk("reset_mis", mis_a, 0);
    chk("reset_tot", tot_a, 0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].bn, vecs[i].in);
      chk($sformatf("vec%0d_out", i), out_a, vecs[i].eo);
      tick();
      chk($sformatf("vec%0d_mis", i), mis_a, vecs[i].em);
      chk($sformatf("vec%0d_tot", i), tot_a, vecs[i].et);
    end
    chk("tbl3_final", 32'(u_a.tbl[3]), 2'b01);
    chk("tbl2_untouched", 32'(u_a.tbl[2]), 2'b01);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic t, p;
      t = (i == 0 || i == 3);
      p = (i == 1);
      step(1, 5, t);
      chk($sformatf("onebit%0d_out", i), out_b, p);
      tick();
    end
    chk("onebit_mis", mis_b, 3);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic t;
      t = (i % 2 == 0);
      step(1, 0, t);
      chk($sformatf("alt%0d_bimodal_out", i), out_a, !t);
      chk($sformatf("alt%0d_gshare_out", i), out_g, i < 2 ? 1'b0 : t);
      tick();
      step(0, 0, !t);
      chk($sformatf("alt%0d_hold_out", i), out_a, t);
      chk($sformatf("alt%0d_sat_tot", i), tot_c, i < 15 ? i + 1 : 15);
      tick();
      chk($sformatf("alt%0d_gated_mis", i), mis_c, i < 15 ? i + 1 : 15);
    end
    chk("alt_bimodal_mis", mis_a, 20);
    chk("alt_bimodal_tot", tot_a, 20);
    chk("alt_gshare_mis", mis_g, 1);
    chk("alt_sat_mis", mis_c, 15);
    chk("alt_sat_tot", tot_c, 15);
    do_reset();
    step(1, 2, 1);
    tick();
    step(1, 2, 1);
    tick();
    step(0, 2, 0);
    chk("trained_out", out_a, 1);
    reset = 0;
    #3;
    reset = 1;
    chk("midreset_out", out_a, 0);
    chk("midreset_mis", mis_a, 0);
    chk("midreset_tot", tot_a, 0);
    chk("midreset_ghr", 32'(u_g.ghr), 0);
    step(1, 2, 1);
    chk("postreset_out", out_a, 0);
    tick();
    chk("postreset_mis", mis_a, 1);
    chk("postreset_tot", tot_a, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
